// File: rtl/vedic_mac_8x8.sv
// vedic_mac_8x8: streaming multiply-accumulate around a Vedic (Urdhva
// Tiryakbhyam) 8x8 multiplier. Operand pairs enter over valid/ready, pass
// through an operand register (S1) and a product register (S2), and are
// summed in batches of N_TERMS. Each batch result is held on a second
// valid/ready handshake until the consumer takes it.

// 2x2 vertical-and-crosswise cell: four partial products and two half adds.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t10, t01, t11, c1;

  assign p[0] = a[0] & b[0];
  assign t10  = a[1] & b[0];
  assign t01  = a[0] & b[1];
  assign t11  = a[1] & b[1];
  assign p[1] = t10 ^ t01;
  assign c1   = t10 & t01;
  assign p[2] = t11 ^ c1;
  assign p[3] = t11 & c1;
endmodule

// 4x4 from four 2x2 cells: low product, summed cross terms, high product.
module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q_ll, q_hl, q_lh, q_hh;
  logic [4:0] mid;
  logic [5:0] upper;

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

  // Cross terms sit at weight 2^2, high term at 2^4; the two low bits of the
  // low term pass straight through.
  assign mid   = {1'b0, q_hl} + {1'b0, q_lh};
  assign upper = {4'b0000, q_ll[3:2]} + {1'b0, mid} + {q_hh, 2'b00};
  assign p     = {upper, q_ll[1:0]};
endmodule

// 8x8 from four 4x4 blocks, same crosswise composition one level up.
module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0]  q_ll, q_hl, q_lh, q_hh;
  logic [8:0]  mid;
  logic [11:0] upper;

  vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q_ll));
  vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q_hl));
  vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q_lh));
  vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q_hh));

  // Worst case 15 + 450 + 3600 = 4065 fits the 12-bit upper sum.
  assign mid   = {1'b0, q_hl} + {1'b0, q_lh};
  assign upper = {8'h00, q_ll[7:4]} + {3'b000, mid} + {q_hh, 4'h0};
  assign p     = {upper, q_ll[3:0]};
endmodule

module vedic_mac_8x8 #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // N_TERMS tops out at 255, so an 8-bit counter covers 0..N_TERMS.
  localparam logic [7:0] N_LAST = 8'(N_TERMS);

  // Unsigned add of a zero-extended product; bit ACC_W is the carry-out.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc_in,
                                             input logic [15:0]      prod_in);
    return {1'b0, acc_in} + {{(ACC_W + 1 - 16){1'b0}}, prod_in};
  endfunction

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic [7:0]       a_p1, b_p1;
  logic             vld_p1;
  logic [15:0]      prod_p1;
  logic [15:0]      prod_p2;
  logic             vld_p2;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   acc_nxt;
  logic             accept, drain_done, handshake;

  // Ready depends only on control state, never on in_valid; clr and reset
  // both block acceptance.
  assign in_ready   = rst_n && !clr && (state == ACCUM) && (cnt < N_LAST);
  assign accept     = in_valid && in_ready;
  // In DRAIN nothing new enters S1, so S1 empty with S2 full means this
  // edge adds the final product.
  assign drain_done = (state == DRAIN) && vld_p2 && !vld_p1;
  assign handshake  = (state == DONE) && out_ready;

  assign out_valid  = (state == DONE);
  assign out_sum    = acc;
  assign out_ovf    = ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state: fill batch, drain pipeline, hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && (cnt == N_LAST - 8'd1)) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
    if (clr) state_nxt = ACCUM;
  end

  // Count pairs accepted in the current batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= 8'd0;
    else if (clr || handshake) cnt <= 8'd0;
    else if (accept)           cnt <= cnt + 8'd1;
  end

  // ---- S1: operand register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= 8'd0;
      b_p1   <= 8'd0;
    end else if (clr) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        a_p1 <= in_a;
        b_p1 <= in_b;
      end
    end
  end

  vedic_8x8 u_mul (.a(a_p1), .b(b_p1), .p(prod_p1));

  // ---- S2: product register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      prod_p2 <= 16'd0;
    end else if (clr) begin
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) prod_p2 <= prod_p1;
    end
  end

  assign acc_nxt = acc_add(acc, prod_p2);

  // ---- Accumulator: add each valid product, sticky carry-out flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr || handshake) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (vld_p2) begin
      acc <= acc_nxt[ACC_W-1:0];
      ovf <= ovf | acc_nxt[ACC_W];
    end
  end

endmodule

// File: tb/tb_vedic_mac_8x8.sv
// tb_vedic_mac_8x8: drives two MAC instances (24-bit and 16-bit accumulators)
// with the same handshake traffic and compares each batch result against a
// plain-arithmetic dot-product model.
module tb_vedic_mac_8x8;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_sum;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_sum16;

  always #5 clk = ~clk;

  vedic_mac_8x8 #(.N_TERMS(N), .ACC_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  vedic_mac_8x8 #(.N_TERMS(N), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_sum(out_sum16), .out_ovf(out_ovf16)
  );

  int     n_chk = 0;
  int     n_err = 0;
  longint mdl_sum = 0;
  int     mdl_n = 0;
  longint exp_q[$];
  int     mon_acc = 0;

  // Handshake monitor: counts accepted pairs as seen at the DUT boundary.
  always @(posedge clk) if (in_valid && in_ready) mon_acc <= mon_acc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    mdl_sum = 0;
    mdl_n   = 0;
    exp_q.delete();
  endtask

  // Offer one pair starting at a negedge; returns at the negedge after accept.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int budget = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mdl_sum += longint'(a) * longint'(b);
    mdl_n++;
    if (mdl_n == N) begin
      exp_q.push_back(mdl_sum);
      mdl_sum = 0;
      mdl_n   = 0;
    end
  endtask

  // Wait for a result, stall it for 'hold' cycles, then take it.
  task automatic get_result(input int hold, input int exp_lat);
    int          cyc = 0;
    longint      e;
    logic [23:0] e24;
    logic [15:0] e16;
    logic        o24, o16;
    chk("drain_ready", in_ready, 0);
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      chk("result_timeout", 64'd0, 64'd1);
      return;
    end
    if (exp_lat >= 0) chk("latency", cyc, exp_lat);
    if (exp_q.size() == 0) begin
      chk("unexpected_result", 64'd1, 64'd0);
      e = 0;
    end else begin
      e = exp_q.pop_front();
    end
    e24 = e[23:0];
    e16 = e[15:0];
    o24 = (e >> 24) != 0;
    o16 = (e >> 16) != 0;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, e24);
      chk("hold_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("sum24", out_sum, e24);
    chk("ovf24", out_ovf, o24);
    chk("valid16", out_valid16, 1);
    chk("sum16", out_sum16, e16);
    chk("ovf16", out_ovf16, o16);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_next", in_ready, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_sum"}, out_sum, 0);
    chk({tag, "_ovf"}, out_ovf, 0);
    chk({tag, "_sum16"}, out_sum16, 0);
  endtask

  initial begin
    int start;
    // Reset state
    #2 rst_n = 1'b0;
    #1 check_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    #1 chk("ready_after_rst", in_ready, 1);
    chk("ready16_after_rst", in_ready16, 1);
    @(negedge clk);

    // Full-scale batch: 8 x (FF,FF) -> 0x07F008; 16-bit copy overflows to 0xF008
    for (int k = 0; k < N; k++) send_pair(8'hFF, 8'hFF);
    get_result(0, 2);
    for (int k = 0; k < N; k++) send_pair(8'd1, 8'd1);
    get_result(0, 2);

    // Gapped input with out_ready held high while no result is pending
    start = mon_acc;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      send_pair(8'(k + 1), 8'd2);
      if (k == 1 || k == 4) repeat (3) @(negedge clk);
    end
    out_ready = 1'b0;
    get_result(0, 2);
    chk("gap_accepts", mon_acc - start, N);

    // Backpressure, then a follow-on batch of 3x5
    for (int k = 0; k < N; k++) send_pair(8'h12 + 8'(k), 8'h34);
    get_result(6, 2);
    for (int k = 0; k < N; k++) send_pair(8'd3, 8'd5);
    get_result(0, 2);

    // Soft clear with S1/S2 full and a pair offered in the same cycle
    for (int k = 0; k < 4; k++) send_pair(8'd10, 8'd10);
    clr = 1'b1; in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
    #1 chk("clr_ready", in_ready, 0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    mdl_clear();
    for (int i = 0; i < 5; i++) begin
      chk("clr_no_out", out_valid, 0);
      @(negedge clk);
    end
    for (int k = 0; k < N; k++) send_pair(8'd1, 8'd1);
    get_result(0, 2);

    // Reset one cycle after the 8th accept (pipeline in DRAIN)
    for (int k = 0; k < N; k++) send_pair(8'hFF, 8'hFF);
    rst_n = 1'b0;
    #1 check_zero("rst_drain");
    repeat (4) @(negedge clk);
    chk("rst_drain_hold", out_valid, 0);
    rst_n = 1'b1;
    mdl_clear();
    #1 chk("rst_drain_ready", in_ready, 1);
    @(negedge clk);
    for (int k = 0; k < N; k++) send_pair(8'd200, 8'd3);
    get_result(1, 2);

    // Randomized batches with random gaps and backpressure
    for (int bt = 0; bt < 8; bt++) begin
      for (int k = 0; k < N; k++) begin
        send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        if (k != N - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      get_result($urandom_range(0, 4), 2);
    end

    chk("no_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vedic_mac_8x8.md
# vedic_mac_8x8

Sequential multiply-accumulate stage built around the `vedic_8x8` combinational multiplier. It accepts 8-bit operand pairs over a valid/ready handshake and registers each pair before the multiplier. It then registers each 16-bit product after the multiplier and sums batches of `N_TERMS` products into an accumulator. Each finished dot-product is presented downstream over a second valid/ready handshake.

## Interface

Parameters:
- `N_TERMS`, default 8: products per batch; legal range 1..255.
- `ACC_W`, default 24: accumulator and result width; legal range 16..32. Overflow is impossible when `ACC_W >= 16 + clog2(N_TERMS)`.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `clr`, input, 1: synchronous soft clear; aborts the current batch.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept an operand pair.
- `in_a`, input, 8: unsigned multiplicand.
- `in_b`, input, 8: unsigned multiplier.
- `out_valid`, output, 1: batch result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_sum`, output, `ACC_W`: batch sum of products, modulo 2^`ACC_W`.
- `out_ovf`, output, 1: sticky flag; set if any accumulate in the batch carried out of `ACC_W`.

## Operation

- **Accept:** an operand pair is accepted on any rising edge where `in_valid && in_ready`.
- **Pipeline:**
  - Stage S1 registers `in_a`/`in_b` plus a valid bit.
  - The `vedic_8x8` instance computes from the S1 registers.
  - Stage S2 registers the 16-bit product plus a valid bit.
  - The accumulator adds the zero-extended S2 product whenever S2 is valid.
- **Accept counter:** `cnt` counts accepted pairs in the current batch, 0..`N_TERMS`.
- **States:**
  - ACCUM: `in_ready = (cnt < N_TERMS)`.
    - Goes to DRAIN on the edge that accepts the `N_TERMS`-th pair.
  - DRAIN: `in_ready = 0`; S1 and S2 empty out.
    - Goes to DONE on the edge where the last product is added; `out_valid` rises on that same edge.
  - DONE: `in_ready = 0`, `out_valid = 1`, `out_sum` and `out_ovf` held stable.
    - Goes to ACCUM on the edge with `out_valid && out_ready`.
    - That edge also sets acc = 0, cnt = 0, `out_ovf` = 0 and `out_valid` = 0.
- **Arithmetic:**
  - The accumulator computes `acc + {0, prod}`, truncated to `ACC_W` bits.
  - The carry-out of that add is ORed into `out_ovf`.
  - `out_sum` is the accumulator register itself.
- **Gaps:** `in_valid` may drop for any number of cycles mid-batch. Bubbles propagate through S1 and S2 without affecting acc.
- **clr:** takes priority over all other activity except reset. It clears S1/S2 valid bits, acc, cnt, `out_ovf` and `out_valid`, and forces state to ACCUM. A pair offered in the same cycle as `clr` is not accepted (`in_ready` is forced 0 while `clr` is 1).
- **`N_TERMS` = 1:** legal. The block goes to DRAIN right after the single accept.

## Timing

- **Reset:** while `rst_n` is low, all of the following are 0: state (ACCUM), cnt, acc, S1/S2 valid and data registers, `out_sum`, `out_ovf`, `out_valid`. `in_ready` is forced 0 while `rst_n` is low.
- **After reset:** `in_ready` reads 1 in the first cycle after `rst_n` deasserts.
- **Reset mid-operation:** takes effect immediately, in any state. The batch is lost and no partial result appears.
- **Latency:** if the last pair is accepted on edge T, then S1 loads at T, S2 at T+1, acc and `out_valid` at T+2. `out_valid` is visible in the cycle after T+2.
- **Throughput:**
  - One pair per cycle within a batch.
  - Between batches there is a 2-cycle drain, plus however long `out_ready` stays low.
  - The first pair of the next batch can be accepted in the cycle after the result handshake edge.
- **Handshake rules:**
  - `out_sum` and `out_ovf` must not change while `out_valid = 1` and `out_ready = 0`.
  - `out_ready` asserted while `out_valid = 0` has no effect.
- `in_ready` is a combinational function of state, cnt, `clr` and `rst_n` only. It does not depend on `in_valid`.

## Test plan

- **Full-scale batch:** `N_TERMS=8`, `ACC_W=24`; 8 back-to-back pairs a=b=0xFF.
  - `out_sum` = 0x07F008 (520200), `out_ovf` = 0.
  - `out_valid` rises on edge T+2 after the 8th accept; `in_ready` is low from edge T until the handshake.
- **Gapped input:** pairs (k+1, 2) for k=0..7, with `in_valid` low for 3 cycles after pairs 2 and 5.
  - `out_sum` = 72.
  - No extra or missing accumulation; exactly 8 accepts are observed.
- **Backpressure:** hold `out_ready` low for 6 cycles after `out_valid` rises.
  - `out_sum` stays stable and `in_ready` stays 0.
  - On the handshake, `out_valid` drops next cycle; the next batch of a=3, b=5 ×8 gives 120.
- **Overflow:** `ACC_W=16`; 8 pairs a=b=0xFF.
  - `out_sum` = 0xF008 (61448), `out_ovf` = 1.
  - The following batch of 1×1 ×8 gives `out_sum` = 8, `out_ovf` = 0.
- **Soft clear:** assert `clr` for 1 cycle after 4 accepts of (10,10) while S1/S2 are still full.
  - Nothing is output.
  - A subsequent batch of 8×(1,1) gives exactly 8.
- **Reset mid-DRAIN:** pull `rst_n` low one cycle after the 8th accept.
  - All outputs read 0 immediately.
  - After release, `in_ready` = 1 and a fresh batch gives the correct sum.
